// File: rtl/qdma_host_stub.sv
// qdma_host_stub: on-chip stand-in for the QDMA streaming engine.
// Sends one H2C packet, captures the returned C2H packet and its CMPT.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, tx_payload    run one transaction on the given H2C packet
//   rx_payload           captured C2H packet, word k at [k*DATA_WIDTH +:]
//   busy, done, err      status; err = {cmpt qid, timeout, length}
//   m_axis_h2c_*         H2C stream driven towards the application
//   s_axis_c2h_*         C2H data and completion streams from it
module qdma_host_stub #(
    parameter int DATA_WIDTH        = 256,
    parameter int QID_WIDTH         = 11,
    parameter int VIP2DUT_WORDS_NUM = 16,
    parameter int DUT2VIP_WORDS_NUM = 16,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [DATA_WIDTH*VIP2DUT_WORDS_NUM-1:0]   tx_payload,
    output logic [DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0]   rx_payload,
    output logic                                      busy,
    output logic                                      done,
    output logic [2:0]                                err,
    output logic [DATA_WIDTH-1:0]                     m_axis_h2c_tdata,
    output logic [QID_WIDTH-1:0]                      m_axis_h2c_tuser_qid,
    output logic [31:0]                               m_axis_h2c_tuser_mdata,
    output logic                                      m_axis_h2c_tvalid,
    output logic                                      m_axis_h2c_tlast,
    input  logic                                      m_axis_h2c_tready,
    input  logic [DATA_WIDTH-1:0]                     s_axis_c2h_tdata,
    input  logic [15:0]                               s_axis_c2h_ctrl_len,
    input  logic [QID_WIDTH-1:0]                      s_axis_c2h_ctrl_qid,
    input  logic                                      s_axis_c2h_ctrl_has_cmpt,
    input  logic                                      s_axis_c2h_tvalid,
    input  logic                                      s_axis_c2h_tlast,
    output logic                                      s_axis_c2h_tready,
    input  logic [10:0]                               s_axis_c2h_cmpt_ctrl_qid,
    input  logic                                      s_axis_c2h_cmpt_tvalid,
    output logic                                      s_axis_c2h_cmpt_tready
);

    localparam int TXW  = DATA_WIDTH * VIP2DUT_WORDS_NUM;
    localparam int MAXB = (VIP2DUT_WORDS_NUM > DUT2VIP_WORDS_NUM) ?
                          VIP2DUT_WORDS_NUM : DUT2VIP_WORDS_NUM;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] TX_PRE  = CW'(VIP2DUT_WORDS_NUM - 2);
    localparam logic [CW-1:0] RX_LAST = CW'(DUT2VIP_WORDS_NUM - 1);
    localparam logic [CW-1:0] RX_NUM  = CW'(DUT2VIP_WORDS_NUM);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   PKT_LEN =
        16'(DUT2VIP_WORDS_NUM * DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        H2C_SEND,
        C2H_RECV,
        CMPT_WAIT,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TXW-1:0]  shadow;
    logic [CW-1:0]   beat_cnt;
    logic [TW-1:0]   timer;

    logic            h2c_hs;
    logic            c2h_hs;
    logic            cmpt_hs;
    logic            wait_st;
    logic            expired;
    logic            len_err;
    logic            unused_qid;

    // The C2H queue id is not checked; only the CMPT queue id is.
    assign unused_qid = ^s_axis_c2h_ctrl_qid;

    // Handshake strobes and status decode straight off the state register.
    assign m_axis_h2c_tvalid      = (state == H2C_SEND);
    assign s_axis_c2h_tready      = (state == C2H_RECV);
    assign s_axis_c2h_cmpt_tready = (state == CMPT_WAIT);
    assign busy                   = (state != IDLE);
    assign done                   = (state == FINISH);
    assign m_axis_h2c_tuser_qid   = '0;

    // The shadow packet shifts down one word per accepted beat, so its
    // low word is always the beat on the bus.
    assign m_axis_h2c_tdata = shadow[DATA_WIDTH-1:0];

    assign h2c_hs  = m_axis_h2c_tvalid & m_axis_h2c_tready;
    assign c2h_hs  = s_axis_c2h_tvalid & s_axis_c2h_tready;
    assign cmpt_hs = s_axis_c2h_cmpt_tvalid & s_axis_c2h_cmpt_tready;
    assign wait_st = (state == C2H_RECV) || (state == CMPT_WAIT);
    assign expired = wait_st && !(c2h_hs || cmpt_hs) &&
                     (timer == TO_LAST);

    // Length problems seen on the current C2H beat.
    always_comb begin
        len_err = 1'b0;
        if (beat_cnt >= RX_NUM) begin
            len_err = 1'b1;
        end
        if ((beat_cnt == '0) && (s_axis_c2h_ctrl_len != PKT_LEN)) begin
            len_err = 1'b1;
        end
        if (s_axis_c2h_tlast && (beat_cnt != RX_LAST)) begin
            len_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = H2C_SEND;
                end
            end
            H2C_SEND: begin
                if (h2c_hs && m_axis_h2c_tlast) begin
                    state_nxt = C2H_RECV;
                end
            end
            C2H_RECV: begin
                if (c2h_hs && s_axis_c2h_tlast) begin
                    state_nxt = s_axis_c2h_ctrl_has_cmpt ?
                                CMPT_WAIT : FINISH;
                end else if (expired) begin
                    state_nxt = FINISH;
                end
            end
            CMPT_WAIT: begin
                if (cmpt_hs || expired) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow                 <= '0;
            beat_cnt               <= '0;
            timer                  <= '0;
            err                    <= '0;
            rx_payload             <= '0;
            m_axis_h2c_tlast       <= 1'b0;
            m_axis_h2c_tuser_mdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shadow           <= tx_payload;
                        err              <= '0;
                        beat_cnt         <= '0;
                        m_axis_h2c_tlast <= (VIP2DUT_WORDS_NUM == 1);
                    end
                end
                H2C_SEND: begin
                    if (h2c_hs) begin
                        if (m_axis_h2c_tlast) begin
                            shadow                 <= '0;
                            beat_cnt               <= '0;
                            timer                  <= '0;
                            m_axis_h2c_tlast       <= 1'b0;
                            m_axis_h2c_tuser_mdata <=
                                m_axis_h2c_tuser_mdata + 32'd1;
                        end else begin
                            shadow           <= shadow >> DATA_WIDTH;
                            beat_cnt         <= beat_cnt + 1'b1;
                            m_axis_h2c_tlast <= (beat_cnt == TX_PRE);
                        end
                    end
                end
                C2H_RECV: begin
                    if (c2h_hs) begin
                        timer <= '0;
                        // Beats past the buffer match no word and drop.
                        for (int k = 0; k < DUT2VIP_WORDS_NUM; k++) begin
                            if (beat_cnt == CW'(k)) begin
                                rx_payload[k*DATA_WIDTH +: DATA_WIDTH]
                                    <= s_axis_c2h_tdata;
                            end
                        end
                        // Saturate so an overlong packet cannot wrap.
                        if (beat_cnt != RX_NUM) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (len_err) begin
                            err[0] <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                        if (expired) begin
                            err[1] <= 1'b1;
                        end
                    end
                end
                CMPT_WAIT: begin
                    if (cmpt_hs) begin
                        timer <= '0;
                        if (s_axis_c2h_cmpt_ctrl_qid != '0) begin
                            err[2] <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                        if (expired) begin
                            err[1] <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    beat_cnt <= '0;
                end
                default: begin
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qdma_host_stub.sv
// tb_qdma_host_stub: scoreboard bench for the QDMA loopback stub.
// Expected H2C beats and completions are queued; a monitor checks them.
module tb_qdma_host_stub;

    localparam int DW   = 256;
    localparam int QW   = 11;
    localparam int NW   = 16;
    localparam int TXW  = DW * NW;
    localparam int TOUT = 4096;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [31:0]   m;
    } h2c_t;

    typedef struct {
        logic [2:0]     e;
        int             nw;
        logic [TXW-1:0] rx;
        int             at;
    } done_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [TXW-1:0]  tx_payload;
    logic [TXW-1:0]  rx_payload;
    logic            busy;
    logic            done;
    logic [2:0]      err;
    logic [DW-1:0]   h2c_tdata;
    logic [QW-1:0]   h2c_qid;
    logic [31:0]     h2c_mdata;
    logic            h2c_tvalid;
    logic            h2c_tlast;
    logic            h2c_tready;
    logic [DW-1:0]   c2h_tdata;
    logic [15:0]     c2h_len;
    logic [QW-1:0]   c2h_qid;
    logic            c2h_has_cmpt;
    logic            c2h_tvalid;
    logic            c2h_tlast;
    logic            c2h_tready;
    logic [10:0]     cmpt_qid;
    logic            cmpt_tvalid;
    logic            cmpt_tready;

    h2c_t  exp_h2c[$];
    done_t exp_done[$];
    int    n_chk;
    int    n_pass;
    int    done_cnt;
    int    cyc;

    qdma_host_stub dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start                    (start),
        .tx_payload               (tx_payload),
        .rx_payload               (rx_payload),
        .busy                     (busy),
        .done                     (done),
        .err                      (err),
        .m_axis_h2c_tdata         (h2c_tdata),
        .m_axis_h2c_tuser_qid     (h2c_qid),
        .m_axis_h2c_tuser_mdata   (h2c_mdata),
        .m_axis_h2c_tvalid        (h2c_tvalid),
        .m_axis_h2c_tlast         (h2c_tlast),
        .m_axis_h2c_tready        (h2c_tready),
        .s_axis_c2h_tdata         (c2h_tdata),
        .s_axis_c2h_ctrl_len      (c2h_len),
        .s_axis_c2h_ctrl_qid      (c2h_qid),
        .s_axis_c2h_ctrl_has_cmpt (c2h_has_cmpt),
        .s_axis_c2h_tvalid        (c2h_tvalid),
        .s_axis_c2h_tlast         (c2h_tlast),
        .s_axis_c2h_tready        (c2h_tready),
        .s_axis_c2h_cmpt_ctrl_qid (cmpt_qid),
        .s_axis_c2h_cmpt_tvalid   (cmpt_tvalid),
        .s_axis_c2h_cmpt_tready   (cmpt_tready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        n_chk++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    function automatic logic [TXW-1:0] mk(input logic [31:0] hi,
                                          input logic [31:0] lo);
        logic [TXW-1:0] r;
        r = '0;
        for (int k = 0; k < NW; k++) begin
            r[k*DW +: DW] = {{7{hi}}, lo + 32'(k)};
        end
        return r;
    endfunction

    task automatic push_h2c(input logic [TXW-1:0] p,
                            input logic [31:0] md);
        h2c_t h;
        for (int k = 0; k < NW; k++) begin
            h.d = p[k*DW +: DW];
            h.l = (k == NW - 1);
            h.m = md;
            exp_h2c.push_back(h);
        end
    endtask

    task automatic push_done(input logic [2:0] e, input int nw,
                             input logic [TXW-1:0] rx, input int at);
        done_t d;
        d.e  = e;
        d.nw = nw;
        d.rx = rx;
        d.at = at;
        exp_done.push_back(d);
    endtask

    // Monitor: every presented H2C beat must match the queue head; it
    // pops only on a handshake, so stalled beats are checked each cycle.
    initial begin
        h2c_t  h;
        done_t d;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (h2c_tvalid) begin
                if (exp_h2c.size() == 0) begin
                    fail_to("h2c_unexpected_beat");
                end else begin
                    h = exp_h2c[0];
                    chk("h2c_tdata", h2c_tdata, h.d);
                    chk("h2c_tlast", DW'(h2c_tlast), DW'(h.l));
                    chk("h2c_mdata", DW'(h2c_mdata), DW'(h.m));
                    chk("h2c_qid", DW'(h2c_qid), '0);
                    if (h2c_tready) begin
                        void'(exp_h2c.pop_front());
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    fail_to("done_unexpected");
                end else begin
                    d = exp_done.pop_front();
                    chk("done_err", DW'(err), DW'(d.e));
                    for (int k = 0; k < d.nw; k++) begin
                        chk($sformatf("rx_word%0d", k),
                            rx_payload[k*DW +: DW], d.rx[k*DW +: DW]);
                    end
                    if (d.at >= 0) begin
                        chk("done_cycle", DW'(cyc), DW'(d.at));
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [TXW-1:0] p);
        tx_payload = p;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        tx_payload = mk(32'hbad0_bad0, 32'hdead_0000);
    endtask

    // Accept nb H2C beats; last_edge is the cycle of the final handshake.
    task automatic accept_h2c(input int nb, input bit rnd,
                              output int last_edge);
        int n;
        int w;
        n = 0;
        w = 0;
        last_edge = -1;
        while (n < nb && w < 400) begin
            h2c_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (h2c_tvalid && h2c_tready) begin
                n++;
                last_edge = cyc + 1;
            end
            w++;
            @(posedge clk);
            #1;
        end
        h2c_tready = 1'b0;
        if (n < nb) begin
            fail_to("h2c_accept");
        end
    endtask

    task automatic send_c2h(input int nb, input logic [15:0] len,
                            input logic hc, input logic [TXW-1:0] p,
                            output int last_edge);
        int w;
        last_edge = -1;
        c2h_len      = len;
        c2h_has_cmpt = hc;
        c2h_qid      = 11'd3;
        for (int i = 0; i < nb; i++) begin
            c2h_tvalid = 1'b1;
            c2h_tdata  = p[i*DW +: DW];
            c2h_tlast  = (i == nb - 1);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!c2h_tready && w < 100);
            if (!c2h_tready) begin
                fail_to("c2h_ready");
            end
            last_edge = cyc + 1;
            @(posedge clk);
            #1;
        end
        c2h_tvalid = 1'b0;
        c2h_tlast  = 1'b0;
    endtask

    task automatic send_cmpt(input logic [10:0] q);
        int w;
        cmpt_tvalid = 1'b1;
        cmpt_qid    = q;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!cmpt_tready && w < 100);
        if (!cmpt_tready) begin
            fail_to("cmpt_ready");
        end
        @(posedge clk);
        #1;
        cmpt_tvalid = 1'b0;
        cmpt_qid    = '0;
    endtask

    task automatic wait_done(input int d0, input int lim);
        int w;
        w = 0;
        while (done_cnt == d0 && w < lim) begin
            @(negedge clk);
            w++;
        end
        if (done_cnt == d0) begin
            fail_to("done_wait");
        end
        @(negedge clk);
        chk("done_once", DW'(done_cnt), DW'(d0 + 1));
        chk("done_low", DW'(done), '0);
        chk("busy_low", DW'(busy), '0);
    endtask

    initial begin
        logic [TXW-1:0] p;
        int e;
        int e2;
        int d0;
        n_chk        = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        tx_payload   = '0;
        h2c_tready   = 1'b0;
        c2h_tdata    = '0;
        c2h_len      = '0;
        c2h_qid      = '0;
        c2h_has_cmpt = 1'b0;
        c2h_tvalid   = 1'b0;
        c2h_tlast    = 1'b0;
        cmpt_qid     = '0;
        cmpt_tvalid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_err", DW'(err), '0);
        chk("rst_tvalid", DW'(h2c_tvalid), '0);
        chk("rst_tdata", h2c_tdata, '0);
        chk("rst_mdata", DW'(h2c_mdata), '0);
        chk("rst_c2h_rdy", DW'(c2h_tready), '0);
        chk("rst_cmpt_rdy", DW'(cmpt_tready), '0);
        chk("rst_rx", DW'(|rx_payload), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Run 1: word k = k+1, full loopback, cmpt qid 0.
        d0 = done_cnt;
        p = mk(32'h0, 32'h1);
        push_h2c(p, 32'd0);
        pulse_start(p);
        chk("busy_after_start", DW'(busy), DW'(1'b1));
        accept_h2c(NW, 1'b0, e);
        send_c2h(NW, 16'd512, 1'b1, p, e2);
        push_done(3'b000, NW, p, -1);
        send_cmpt(11'd0);
        wait_done(d0, 200);

        // Run 2: random ready, a stray start while busy is ignored.
        d0 = done_cnt;
        p = mk(32'h1111_2222, 32'h100);
        push_h2c(p, 32'd1);
        pulse_start(p);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        accept_h2c(NW, 1'b1, e);
        send_c2h(NW, 16'd512, 1'b1, p, e2);
        push_done(3'b000, NW, p, -1);
        send_cmpt(11'd0);
        wait_done(d0, 200);

        // Run 3: short C2H packet of 12 beats.
        d0 = done_cnt;
        p = mk(32'h3333_4444, 32'h200);
        push_h2c(p, 32'd2);
        pulse_start(p);
        accept_h2c(NW, 1'b0, e);
        send_c2h(12, 16'd384, 1'b0, p, e2);
        push_done(3'b001, 12, p, -1);
        wait_done(d0, 200);

        // Run 4: no C2H response at all.
        d0 = done_cnt;
        p = mk(32'h5555_6666, 32'h300);
        push_h2c(p, 32'd3);
        pulse_start(p);
        accept_h2c(NW, 1'b0, e);
        push_done(3'b010, 0, '0, e + TOUT);
        wait_done(d0, TOUT + 200);

        // Run 5: completion on the wrong queue.
        d0 = done_cnt;
        p = mk(32'h7777_8888, 32'h400);
        push_h2c(p, 32'd4);
        pulse_start(p);
        accept_h2c(NW, 1'b0, e);
        send_c2h(NW, 16'd512, 1'b1, p, e2);
        push_done(3'b100, NW, p, -1);
        send_cmpt(11'd5);
        wait_done(d0, 200);

        // Run 6: no completion, finish right after tlast.
        d0 = done_cnt;
        p = mk(32'h9999_aaaa, 32'h500);
        push_h2c(p, 32'd5);
        pulse_start(p);
        accept_h2c(NW, 1'b0, e);
        send_c2h(NW, 16'd512, 1'b0, p, e2);
        push_done(3'b000, NW, p, e2);
        wait_done(d0, 200);

        // Reset while beat 7 is stalled on the bus.
        p = mk(32'hbbbb_cccc, 32'h600);
        push_h2c(p, 32'd6);
        pulse_start(p);
        accept_h2c(7, 1'b0, e);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", DW'(h2c_tvalid), '0);
        chk("arst_busy", DW'(busy), '0);
        chk("arst_tdata", h2c_tdata, '0);
        chk("arst_mdata", DW'(h2c_mdata), '0);
        exp_h2c.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Run 7: restart after reset begins from word 0, mdata 0.
        d0 = done_cnt;
        p = mk(32'hdddd_eeee, 32'h700);
        push_h2c(p, 32'd0);
        pulse_start(p);
        accept_h2c(NW, 1'b0, e);
        send_c2h(NW, 16'd512, 1'b1, p, e2);
        push_done(3'b000, NW, p, -1);
        send_cmpt(11'd0);
        wait_done(d0, 200);

        chk("h2c_q_empty", DW'(exp_h2c.size()), '0);
        chk("done_q_empty", DW'(exp_done.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
